// File: rtl/pad_input_filter_bank.sv
// Input pad front-end: per-channel synchroniser, debounce filter and edge pulses,
// plus pad attribute registers written through a valid/ready port with a settle window.
module pad_input_filter_bank #(
  parameter int NUM_CH      = 8,
  parameter int PADATTR     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int SETTLE_CYC  = 8,
  parameter logic [PADATTR-1:0] ATTR_RST = PADATTR'(16'h0004),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH-1:0]           pad_c_i,
  input  logic [NUM_CH-1:0]           filt_en_i,
  input  logic [FILT_W-1:0]           thresh_i,
  output logic [NUM_CH-1:0]           data_o,
  output logic [NUM_CH-1:0]           rise_o,
  output logic [NUM_CH-1:0]           fall_o,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [CH_W-1:0]             cfg_ch_i,
  input  logic [PADATTR-1:0]          cfg_attr_i,
  output logic                        cfg_err_o,
  output logic [NUM_CH-1:0]           busy_o,
  output logic [NUM_CH*PADATTR-1:0]   pad_attributes_o
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]   SETTLE_V = SW'(SETTLE_CYC);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  typedef enum logic {IDLE, SETTLE} cfg_state_e;

  logic [NUM_CH-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]  s;
  logic [NUM_CH-1:0]  filt_q, filt_d, rise_q, fall_q;
  logic [FILT_W-1:0]  cnt_q [NUM_CH];
  logic [FILT_W-1:0]  cnt_d [NUM_CH];

  cfg_state_e         state_q, state_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic               err_q, err_d;
  logic               wr_en;
  logic               ch_ok;
  logic [NUM_CH-1:0]  ch_onehot;
  logic [NUM_CH*PADATTR-1:0] attr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_c_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A channel in its settle window is frozen so pad switching transients are ignored
  always_comb begin
    filt_d = filt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_d[k] = '0;
      if (!busy_q[k]) begin
        if (!filt_en_i[k]) begin
          filt_d[k] = s[k];
        end else if (s[k] != filt_q[k]) begin
          if (cnt_q[k] >= thresh_i) filt_d[k] = s[k];
          else if (cnt_q[k] != '1)  cnt_d[k]  = cnt_q[k] + 1'b1;
          else                      cnt_d[k]  = cnt_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign ch_ok     = {1'b0, cfg_ch_i} < NUM_CH_V;
  assign ch_onehot = NUM_CH'(1) << cfg_ch_i;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    cfg_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          if (ch_ok) begin
            wr_en    = 1'b1;
            settle_d = SETTLE_V;
            busy_d   = ch_onehot;
            state_d  = SETTLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (settle_q == SW'(1)) begin
          state_d  = IDLE;
          busy_d   = '0;
          settle_d = '0;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      settle_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      attr_q <= {NUM_CH{ATTR_RST}};
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++)
        if (ch_onehot[k]) attr_q[k*PADATTR +: PADATTR] <= cfg_attr_i;
    end
  end

  assign data_o           = filt_q;
  assign rise_o           = rise_q;
  assign fall_o           = fall_q;
  assign busy_o           = busy_q;
  assign cfg_err_o        = err_q;
  assign pad_attributes_o = attr_q;

endmodule

// File: tb/tb_pad_input_filter_bank.sv
// Randomised scoreboard bench for pad_input_filter_bank with a run-length filter
// model and a countdown config model; a second 6-channel instance covers bad channels.
module tb_pad_input_filter_bank;

  localparam int NCH    = 8;
  localparam int SYNC   = 2;
  localparam int SETTLE = 8;
  localparam logic [15:0] ATTR_RST = 16'h0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   pad_c, filt_en, data, rise, fall, busy;
  logic [3:0]   thresh;
  logic         cfg_valid, cfg_ready, cfg_err;
  logic [2:0]   cfg_ch;
  logic [15:0]  cfg_attr;
  logic [127:0] attrs;

  logic [5:0]   data2, rise2, fall2, busy2;
  logic         cfg_valid2, cfg_ready2, cfg_err2;
  logic [2:0]   cfg_ch2;
  logic [15:0]  cfg_attr2;
  logic [95:0]  attrs2;

  pad_input_filter_bank dut (
    .clk_i(clk), .rst_i(rst), .pad_c_i(pad_c), .filt_en_i(filt_en), .thresh_i(thresh),
    .data_o(data), .rise_o(rise), .fall_o(fall), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch), .cfg_attr_i(cfg_attr),
    .cfg_err_o(cfg_err), .busy_o(busy), .pad_attributes_o(attrs)
  );

  pad_input_filter_bank #(.NUM_CH(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .pad_c_i(6'd0), .filt_en_i(6'd0), .thresh_i(4'd0),
    .data_o(data2), .rise_o(rise2), .fall_o(fall2), .cfg_valid_i(cfg_valid2),
    .cfg_ready_o(cfg_ready2), .cfg_ch_i(cfg_ch2), .cfg_attr_i(cfg_attr2),
    .cfg_err_o(cfg_err2), .busy_o(busy2), .pad_attributes_o(attrs2)
  );

  typedef struct {
    logic [7:0]   data, rise, fall, busy;
    logic         ready, err;
    logic [127:0] attrs;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [7:0]     m_filt, m_old, m_s, m_busy;
  int           m_run [NCH];
  bit [7:0]     m_hist[$];
  int           m_left, m_ch;
  logic [127:0] m_attr;
  exp_t         m_e, mon_e;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    m_filt = '0;
    for (int k = 0; k < NCH; k++) m_run[k] = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(8'h00);
    m_left = 0;
    m_ch   = 0;
    m_attr = {NCH{ATTR_RST}};
  endtask

  // Model: s is the pad value SYNC edges old; a channel commits once s has differed
  // from the filtered value for more than T consecutive evaluations.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelReset();
      sbq.delete();
    end else begin
      m_s = m_hist.pop_front();
      m_hist.push_back(pad_c);
      m_busy = (m_left > 0) ? (8'd1 << m_ch) : 8'd0;
      m_old  = m_filt;
      for (int k = 0; k < NCH; k++) begin
        if (m_busy[k]) begin
          m_run[k] = 0;
        end else if (!filt_en[k]) begin
          m_filt[k] = m_s[k];
          m_run[k]  = 0;
        end else if (m_s[k] == m_filt[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] > int'(thresh)) begin
            m_filt[k] = m_s[k];
            m_run[k]  = 0;
          end
        end
      end
      if (m_left == 0 && cfg_valid) begin
        m_attr[int'(cfg_ch)*16 +: 16] = cfg_attr;
        m_left = SETTLE;
        m_ch   = int'(cfg_ch);
      end else if (m_left > 0) begin
        m_left--;
      end
      m_e.data  = m_filt;
      m_e.rise  = m_filt & ~m_old;
      m_e.fall  = ~m_filt & m_old;
      m_e.busy  = (m_left > 0) ? (8'd1 << m_ch) : 8'd0;
      m_e.ready = (m_left == 0);
      m_e.err   = 1'b0;
      m_e.attrs = m_attr;
      sbq.push_back(m_e);
    end
  end

  // Monitor: one registered output set per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (sbq.size() == 0) begin
        checkOutput("scoreboard_empty", 128'd0, 128'd1);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("data_o", 128'(data), 128'(mon_e.data));
        checkOutput("rise_o", 128'(rise), 128'(mon_e.rise));
        checkOutput("fall_o", 128'(fall), 128'(mon_e.fall));
        checkOutput("busy_o", 128'(busy), 128'(mon_e.busy));
        checkOutput("cfg_ready_o", 128'(cfg_ready), 128'(mon_e.ready));
        checkOutput("cfg_err_o", 128'(cfg_err), 128'(mon_e.err));
        checkOutput("pad_attributes_o", attrs, mon_e.attrs);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] en, input logic [3:0] t,
                               input logic v, input logic [2:0] ch, input logic [15:0] a);
    @(negedge clk);
    #1;
    pad_c = p; filt_en = en; thresh = t; cfg_valid = v; cfg_ch = ch; cfg_attr = a;
  endtask

  logic [7:0] rp, ren;
  logic [3:0] rt;

  initial begin
    modelReset();
    pad_c = '0; filt_en = '0; thresh = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_attr = '0;
    cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_attr2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", 128'(data), 128'd0);
    checkOutput("reset_ready", 128'(cfg_ready), 128'd1);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_err", 128'(cfg_err), 128'd0);
    checkOutput("reset_attrs", attrs, {NCH{ATTR_RST}});
    @(negedge clk);
    #1 rst = 1'b0;

    // Bypass latency and single rise pulse
    repeat (6) applyStimulus(8'hA5, 8'h00, 4'd0, 1'b0, 3'd0, 16'h0);
    repeat (6) applyStimulus(8'h00, 8'h00, 4'd0, 1'b0, 3'd0, 16'h0);
    // Glitch rejection then committed high on channel 0
    repeat (3)  applyStimulus(8'h01, 8'h01, 4'd4, 1'b0, 3'd0, 16'h0);
    repeat (6)  applyStimulus(8'h00, 8'h01, 4'd4, 1'b0, 3'd0, 16'h0);
    repeat (10) applyStimulus(8'h01, 8'h01, 4'd4, 1'b0, 3'd0, 16'h0);

    // Out-of-range and in-range writes on the 6-channel instance
    @(negedge clk);
    #1 cfg_valid2 = 1'b1; cfg_ch2 = 3'd7; cfg_attr2 = 16'hFFFF;
    @(posedge clk);
    #1;
    checkOutput("err6_pulse", 128'(cfg_err2), 128'd1);
    checkOutput("err6_ready", 128'(cfg_ready2), 128'd1);
    checkOutput("err6_attrs", 128'(attrs2), 128'({6{ATTR_RST}}));
    checkOutput("err6_busy", 128'(busy2), 128'd0);
    @(negedge clk);
    #1 cfg_valid2 = 1'b0;
    @(posedge clk);
    #1 checkOutput("err6_clear", 128'(cfg_err2), 128'd0);
    @(negedge clk);
    #1 cfg_valid2 = 1'b1; cfg_ch2 = 3'd5; cfg_attr2 = 16'hBEEF;
    @(posedge clk);
    #1;
    checkOutput("wr6_attrs", 128'(attrs2), 128'({16'hBEEF, {5{ATTR_RST}}}));
    checkOutput("wr6_busy", 128'(busy2), 128'(6'b100000));
    checkOutput("wr6_ready", 128'(cfg_ready2), 128'd0);
    @(negedge clk);
    #1 cfg_valid2 = 1'b0;

    // Channel 3 write with pad toggles during its settle window
    applyStimulus(8'h01, 8'h08, 4'd1, 1'b1, 3'd3, 16'h0005);
    for (int i = 0; i < 10; i++)
      applyStimulus((i % 2 == 0) ? 8'h09 : 8'h01, 8'h08, 4'd1, 1'b0, 3'd0, 16'h0);
    // Back-to-back queued writes
    applyStimulus(8'h01, 8'h00, 4'd0, 1'b1, 3'd1, 16'h1111);
    repeat (12) applyStimulus(8'h01, 8'h00, 4'd0, 1'b1, 3'd2, 16'h2222);

    // Randomised traffic
    rp = 8'h00; ren = 8'h00; rt = 4'd2;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        ren = 8'($urandom);
        rt  = ($urandom_range(7) == 0) ? 4'hF : 4'($urandom_range(5));
      end
      if ($urandom_range(3) == 0) rp = rp ^ (8'd1 << $urandom_range(7));
      if ($urandom_range(15) == 0) rp = 8'($urandom);
      applyStimulus(rp, ren, rt, ($urandom_range(7) == 0), 3'($urandom_range(7)), 16'($urandom));
    end

    // Reset in the middle of a settle window
    repeat (12) applyStimulus(8'hFF, 8'h00, 4'd0, 1'b0, 3'd0, 16'h0);
    applyStimulus(8'hFF, 8'h00, 4'd0, 1'b1, 3'd5, 16'h5A5A);
    repeat (3) applyStimulus(8'hFF, 8'h00, 4'd0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 128'(busy), 128'd0);
    checkOutput("midrst_ready", 128'(cfg_ready), 128'd1);
    checkOutput("midrst_attrs", attrs, {NCH{ATTR_RST}});
    checkOutput("midrst_data", 128'(data), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) applyStimulus(8'h3C, 8'h00, 4'd0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
